alu_exec_unit: RTL

//  Parametrised EX-stage execution unit: decodes ALUOp_i/funct_i internally and executes the op.

---
 rtl/alu_exec_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle ALU ops, iterative shift-add multiply and, when the
// ALU_DIV_EN macro is defined, an unsigned restoring divider (funct 011010).
module alu_exec_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic             busy_o
);
  localparam int unsigned N = WIDTH / BITS_PER_CYCLE;
`ifdef ALU_DIV_EN
  localparam int unsigned MaxSteps = WIDTH;
`else
  localparam int unsigned MaxSteps = N;
`endif
  localparam int unsigned CntW = $clog2(MaxSteps + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
  typedef enum logic [2:0] {OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul, OpDiv, OpIll} op_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;

  op_e              op;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] partial, mcand, mplier;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   trial;
`endif

  always_comb begin
    op = OpIll;
    unique case (ALUOp_i)
      2'b00: op = OpAdd;
      2'b01: op = OpSub;
      2'b11: op = OpOr;
      2'b10: begin
        case (funct_i)
          6'b100100: op = OpAnd;
          6'b100101: op = OpOr;
          6'b100000: op = OpAdd;
          6'b100010: op = OpSub;
          6'b101010: op = OpSlt;
          6'b011000: op = OpMul;
`ifdef ALU_DIV_EN
          6'b011010: op = OpDiv;
`endif
          default:   op = OpIll;
        endcase
      end
      default: op = OpIll;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:   alu_res = data1_i + data2_i;
      OpSub:   alu_res = data1_i - data2_i;
      OpAnd:   alu_res = data1_i & data2_i;
      OpOr:    alu_res = data1_i | data2_i;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
      default: alu_res = '0;
    endcase
  end

  // Partial product of the shifted multiplicand with the low BITS_PER_CYCLE multiplier bits.
  always_comb begin
    partial = '0;
    mcand   = opa_q;
    mplier  = opb_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[0]) partial = partial + mcand;
      mcand  = mcand << 1;
      mplier = mplier >> 1;
    end
  end

`ifdef ALU_DIV_EN
  // Remainder lives in acc_q, dividend/quotient shift through opa_q, divisor in opb_q.
  always_comb begin
    trial = {acc_q, opa_q[WIDTH-1]} - {1'b0, opb_q};
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: begin
        if (valid_i) begin
          opa_d = data1_i;
          opb_d = data2_i;
          acc_d = '0;
          cnt_d = '0;
          if (op == OpMul) begin
            state_d = StMul;
          end else if (op == OpDiv) begin
            state_d = StDiv;
          end else begin
            data_d    = alu_res;
            valid_d   = 1'b1;
            illegal_d = (op == OpIll);
          end
        end
      end
      StMul: begin
        acc_d = acc_q + partial;
        opa_d = opa_q << BITS_PER_CYCLE;
        opb_d = opb_q >> BITS_PER_CYCLE;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          state_d   = StIdle;
          cnt_d     = '0;
          data_d    = acc_d;
          valid_d   = 1'b1;
          illegal_d = 1'b0;
        end
      end
`ifdef ALU_DIV_EN
      StDiv: begin
        acc_d = trial[WIDTH] ? {acc_q[WIDTH-2:0], opa_q[WIDTH-1]} : trial[WIDTH-1:0];
        opa_d = {opa_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d   = StIdle;
          cnt_d     = '0;
          data_d    = opa_d;
          valid_d   = 1'b1;
          illegal_d = 1'b0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready_o   = (state_q == StIdle);
  assign busy_o    = ~ready_o;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign zero_o    = (data_q == '0);
  assign illegal_o = illegal_q;

endmodule
